// File: rtl/des_key_loader.sv
// Assembles a 192-bit 3DES key bundle from WORD_W-bit beats and holds it for des_key_schedule.
// Optional byte parity checking is compiled in when DES_KEY_PARITY_EN is defined.
module des_key_loader #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_is_encrypt,
  output logic [0:191]      Sk,
  output logic              is_encrypt,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              parity_err,
  output logic              weak_key,
  output logic [1:0]        dbg_state
);

  localparam int NUM_WORDS = 192 / WORD_W;
  localparam int CNT_W     = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Handshake: a beat transfers on a rising edge where in_valid & in_ready
  // (and clear is low). in_ready and key_valid depend only on the state register.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    key_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && cnt == LAST_CNT) state_next = HOLD;
      end
      HOLD: begin
        key_valid = 1'b1;
        if (key_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next = IDLE;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt        <= '0;
      Sk         <= '0;
      is_encrypt <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      Sk         <= '0;
      is_encrypt <= 1'b0;
    end else begin
      if (accept) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          if (cnt == CNT_W'(w)) Sk[w*WORD_W +: WORD_W] <= in_data;
        end
        if (state == IDLE) is_encrypt <= in_is_encrypt;
        if (cnt != LAST_CNT) cnt <= cnt + CNT_W'(1);
      end
      if (state == HOLD && key_ack) cnt <= '0;
    end
  end

  // Bit 8n+7 of each key is its parity bit (LSB of each byte in MSB-first order).
  localparam logic [0:63] KEY_MASK = {8{8'hFE}};
  logic [0:63] k1_masked;
  logic [0:63] k2_masked;
  logic [0:63] k3_masked;

  assign k1_masked = Sk[0:63]    & KEY_MASK;
  assign k2_masked = Sk[64:127]  & KEY_MASK;
  assign k3_masked = Sk[128:191] & KEY_MASK;
  assign weak_key  = key_valid & ((k1_masked == k2_masked) | (k2_masked == k3_masked));

`ifdef DES_KEY_PARITY_EN
  logic [23:0] byte_odd;
  always_comb begin
    byte_odd = '0;
    for (int n = 0; n < 24; n++) byte_odd[n] = ^Sk[8*n +: 8];
  end
  assign parity_err = key_valid & ~(&byte_odd);
`else
  assign parity_err = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: doc/des_key_loader.md
# des_key_loader

Upstream feeder for `des_key_schedule`. The block accepts a 192-bit 3DES key bundle (K1‖K2‖K3) as a stream of `WORD_W`-bit beats with a valid/ready handshake, typically from the ECDH shared-secret path. It assembles the bundle into `Sk[0:191]` and latches the direction bit. It then holds both stable with `key_valid` until the consumer acknowledges, and flags parity errors and degenerate keying.

## Interface
Parameters:
- `WORD_W`, 32, beat width. Legal values are 8, 16, 32, 64.
- Derived: `NUM_WORDS = 192/WORD_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous abort.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: loader can accept a beat.
- `in_data` in `WORD_W`: key beat. The first beat maps to `Sk[0:WORD_W-1]`; later beats fill higher indices.
- `in_is_encrypt` in 1: direction bit, sampled with the first beat only.
- `Sk` out 192: assembled key bundle, index 0 = MSB of K1. Drives `des_key_schedule.Sk`.
- `is_encrypt` out 1: latched direction. Drives `des_key_schedule.is_encrypt`.
- `key_valid` out 1: `Sk` and `is_encrypt` are complete and stable.
- `key_ack` in 1: consumer has taken the key. Only meaningful while `key_valid` = 1.
- `parity_err` out 1: some key byte has even parity. Valid while `key_valid` = 1.
- `weak_key` out 1: degenerate keying, K1==K2 or K2==K3 with parity bits masked. Valid while `key_valid` = 1.

## Operation
States:
- **IDLE**: `in_ready` = 1. An accepted beat (`in_valid & in_ready`) writes word 0 into `Sk`, latches `in_is_encrypt`, sets `cnt` = 1, and moves to LOAD.
- **LOAD**: `in_ready` = 1. Each accepted beat writes word `cnt` and increments `cnt`. The beat with `cnt == NUM_WORDS-1` moves to HOLD. Cycles without a beat (`in_valid` = 0) leave all state unchanged.
- **HOLD**: `in_ready` = 0 and `key_valid` = 1. `Sk` and `is_encrypt` are frozen. `key_ack` = 1 moves to IDLE.

Rules:
- `cnt` has width `$clog2(NUM_WORDS)`. It resets to 0 on entry to IDLE and never wraps past `NUM_WORDS-1`.
- `Sk` keeps its contents after `key_ack`. It is overwritten word by word by the next load. Consumers must not sample `Sk` while `key_valid` = 0.
- `weak_key` is combinational from `Sk`. Compare bits `[0:63]` vs `[64:127]` and `[64:127]` vs `[128:191]`, excluding parity bit positions `8n+7`. The flag is gated by `key_valid`.
- `clear` = 1 in any state:
  - next state IDLE, `cnt` = 0, `Sk` = 0, `is_encrypt` = 0.
  - A beat presented in the same cycle is dropped, even though `in_ready` may be 1.
  - `clear` has priority over `key_ack`.
- Reset: state IDLE, `cnt` = 0, `Sk` = 0, `is_encrypt` = 0, `key_valid` = 0, `parity_err` = 0, `weak_key` = 0. `in_ready` = 1 immediately after `n_rst` deasserts.
- Asserting `n_rst` mid-load discards the partial key with no residue.

## Timing
- `in_ready` and `key_valid` are decoded from the registered state, so there is no combinational path from any input.
- Throughput is one beat per cycle. If the last beat is accepted at edge t, `key_valid` = 1 from t+1.
- Total load latency is `NUM_WORDS` cycles with back-to-back beats (6 cycles for `WORD_W` = 32).
- If `key_ack` is sampled high at edge t, `key_valid` = 0 and `in_ready` = 1 from t+1. The next key's first beat can therefore be accepted at edge t+1.
- `key_ack` while not in HOLD is ignored.
- `parity_err` and `weak_key` settle in the same cycle `key_valid` rises, and stay stable through HOLD.

## Configuration
- `DES_KEY_PARITY_EN` defined:
  - Each of the 24 bytes of `Sk` is checked for odd parity.
  - `parity_err` = `key_valid & (any byte has even parity)`.
- `DES_KEY_PARITY_EN` undefined:
  - No parity logic is generated and `parity_err` is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Reset and idle**: hold `n_rst` = 0, then release. Expect `in_ready` = 1, `key_valid` = 0, `Sk` = 0, `parity_err` = 0, `weak_key` = 0.
- **Nominal load** (`WORD_W` = 32):
  - Stimulus: back-to-back beats 01234567, 89ABCDEF, 23456789, ABCDEF01, 456789AB, CDEF0123, with `in_is_encrypt` = 1 on the first beat.
  - Expect `key_valid` = 1 exactly one cycle after the 6th beat.
  - Expect `Sk` = 0123456789ABCDEF_23456789ABCDEF01_456789ABCDEF0123, `is_encrypt` = 1, `parity_err` = 0, `weak_key` = 0.
  - `key_ack` pulse: expect `key_valid` = 0 and `in_ready` = 1 on the next cycle.
- **Bubbles and backpressure**:
  - Same key with `in_valid` toggling 1,0,1,0: expect `key_valid` only after the 6th accepted beat.
  - While in HOLD, drive `in_valid` = 1 with a different word: `in_ready` = 0 and `Sk` is unchanged.
- **Parity error**: first beat 00234567 (byte 0x00 has even parity). Expect `parity_err` = 1 with `DES_KEY_PARITY_EN` defined, and 0 without it.
- **Weak keying**: K3 beats equal to K2 (23456789, ABCDEF01). Expect `weak_key` = 1. Repeat with K2 = 0123456789ABCDEE vs K1 = 0123456789ABCDEF (differs only in a parity bit): expect `weak_key` = 1.
- **Abort**:
  - `clear` after 3 beats: expect IDLE and `Sk` = 0 next cycle. A fresh 6-beat load then completes normally.
  - Repeat with `n_rst` pulsed low mid-load: same result.
  - `clear` and `key_ack` asserted together in HOLD: expect `Sk` = 0.
